norm_seq: RTL and testbench
===========================

NORM_SEQ -- requirements
Module: norm_seq

Interface
REQ-001 Parameter: N_WEIGHTS, default 20, number of weight beats per norm operation.
REQ-002 Parameter: WEIGHT_W, default 10, signed weight width.
REQ-003 Parameter: MAX_ROOT, default 42, saturation value of the root result.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: start  input  1  single-cycle request to begin one norm operation.
REQ-007 Port: busy  output  1  high in every state except IDLE.
REQ-008 Port: in_valid  input  1  weight beat valid.
REQ-009 Port: in_ready  output  1  block accepts a weight beat.
REQ-010 Port: in_data  input  WEIGHT_W  signed two's-complement weight.
REQ-011 Port: out_valid  output  1  result valid.
REQ-012 Port: out_ready  input  1  downstream accepts result.
REQ-013 Port: result  output  10  {1'b0, root[8:0]}; unsigned integer root, MSB always 0.

Function
REQ-014 The block SHALL implement states IDLE, ACCUM, ROOT and DONE.
REQ-015 In IDLE, start=1 SHALL clear the accumulator and beat counter and move to ACCUM on the next edge; start SHALL be ignored in all other states.
REQ-016 in_ready SHALL be 1 only in ACCUM.
REQ-017 A beat transfers on the edge where in_valid and in_ready are both 1; in_valid=0 cycles SHALL leave all state unchanged.
REQ-018 Each transferred beat SHALL add in_data*in_data to a 23-bit unsigned accumulator; no truncation or overflow for N_WEIGHTS=20 (max 20*262144=5242880).
REQ-019 After beat N_WEIGHTS transfers, the block SHALL move to ROOT with root=0; in_ready SHALL be 0 on the following cycle.
REQ-020 In ROOT, each cycle SHALL increment root if root<MAX_ROOT and (root+1)^2 <= accumulator, otherwise move to DONE with root unchanged.
REQ-021 Final root SHALL equal min(floor(sqrt(accumulator)), MAX_ROOT); ROOT occupancy is root+1 cycles.
REQ-022 In DONE, out_valid SHALL be 1 and result SHALL be stable; the result transfers when out_ready=1, then the block returns to IDLE on that edge.
REQ-023 out_valid SHALL be 0 in every state other than DONE; out_ready SHALL be ignored outside DONE.
REQ-024 start asserted in the same cycle as the DONE transfer SHALL be ignored; a new operation needs start in IDLE.
REQ-025 result SHALL hold its last transferred value outside DONE.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, accumulator=0, counter=0, root=0, result=0, out_valid=0, in_ready=0, busy=0, regardless of state.
REQ-027 Reset in mid-operation SHALL discard all partial data; no out_valid pulse SHALL follow.
REQ-028 rst SHALL take priority over start and every handshake in the same cycle.

Structure
REQ-029 Shared package norm_pkg SHALL hold WEIGHT_W, N_WEIGHTS, ACC_W=23, ROOT_W=9, MAX_ROOT and the state enumeration.
REQ-030 The ROOT compare/increment step SHALL be a sub-module norm_sqrt_iter (inputs accumulator and root; outputs next root and done flag), purely combinational.
REQ-031 The top SHALL contain exactly one multiplier (WEIGHT_W x WEIGHT_W signed).

Verification
REQ-032 20 beats of 0, back-to-back -> result=0, out_valid 2 cycles after last beat (1 ROOT cycle).
REQ-033 20 beats of +1 -> accumulator 20, result=4, ROOT occupies 5 cycles.
REQ-034 Beats 3, -4, then 18 zeros with in_valid low every other cycle -> result=5; no beats lost or duplicated.
REQ-035 20 beats of -512 -> accumulator 5242880, result=42 (saturated), ROOT occupies 43 cycles.
REQ-036 Completed operation, out_ready held low 5 cycles -> out_valid and result=5 stable for all 5 cycles; IDLE after out_ready=1.
REQ-037 rst=1 after beat 7 in ACCUM -> next cycle IDLE, busy=0, in_ready=0; then a fresh 20x(+1) run -> result=4.

Source files
------------

// File: rtl/norm_pkg.sv
// norm_pkg
// Shared definitions for the weight-norm sequencer: default sizing of the
// weight stream, accumulator and root widths, the root saturation limit and
// the controller state enumeration.
// No ports (package only).

package norm_pkg;

   // Number of weight beats that make up one norm operation.
   localparam int N_WEIGHTS = 20;

   // Width of one signed two's-complement weight.
   localparam int WEIGHT_W = 10;

   // Sum of squares for N_WEIGHTS full-scale weights (20 * 512^2 = 5242880)
   // fits exactly in 23 unsigned bits.
   localparam int ACC_W = 23;

   // Root register width; the published result is {1'b0, root}.
   localparam int ROOT_W = 9;

   // Largest root the iterative search is allowed to reach.
   localparam int MAX_ROOT = 42;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      ROOT  = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage : norm_pkg

// File: rtl/norm_sqrt_iter.sv
// norm_sqrt_iter
// One step of the linear integer square-root search. Given the sum of
// squares and the current root candidate, it decides whether the root may
// grow by one (next candidate squared still fits and the saturation limit is
// not reached) and presents the next root value. Purely combinational.
// Ports:
//   acc_i      sum of squares being rooted
//   root_i     current root candidate
//   rootNext_o root after this step (root_i + 1, or root_i when finished)
//   done_o     high when the root can no longer grow

module norm_sqrt_iter #(
   parameter int MAX_ROOT = norm_pkg::MAX_ROOT
) (
   input  logic [norm_pkg::ACC_W-1:0]  acc_i,
   input  logic [norm_pkg::ROOT_W-1:0] root_i,
   output logic [norm_pkg::ROOT_W-1:0] rootNext_o,
   output logic                        done_o
);
   import norm_pkg::*;

   localparam int SQ_W = 2 * (ROOT_W + 1);

   logic [ROOT_W:0] rootInc;
   logic [SQ_W-1:0] incSquare;
   logic            grow;

   // The incremented candidate carries one extra bit so that squaring it can
   // never wrap, even at the top of the root range.
   assign rootInc   = {1'b0, root_i} + (ROOT_W + 1)'(1);
   assign incSquare = SQ_W'(rootInc) * SQ_W'(rootInc);

   // Grow only while below the saturation limit and while the next candidate
   // squared still does not exceed the accumulated value.
   assign grow = (root_i < ROOT_W'(MAX_ROOT)) &&
                 (ACC_W'(incSquare) <= acc_i);

   assign rootNext_o = grow ? rootInc[ROOT_W-1:0] : root_i;
   assign done_o     = ~grow;

endmodule : norm_sqrt_iter

// File: rtl/norm_seq.sv
// norm_seq
// Computes min(floor(sqrt(sum of w^2)), MAX_ROOT) over a stream of
// N_WEIGHTS signed weights. A start pulse in IDLE opens the operation, the
// weights arrive through a valid/ready handshake and are squared and summed,
// the root is then found by an incrementing search, and the result is held
// in DONE until the downstream accepts it.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start               begin one operation (only honoured in IDLE)
//   busy                high whenever the controller is not in IDLE
//   in_valid/in_ready   weight beat handshake, in_data is the signed weight
//   out_valid/out_ready result handshake
//   result              {1'b0, root}, holds the last delivered root

module norm_seq #(
   parameter int N_WEIGHTS = norm_pkg::N_WEIGHTS,
   parameter int WEIGHT_W  = norm_pkg::WEIGHT_W,
   parameter int MAX_ROOT  = norm_pkg::MAX_ROOT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   output logic                       busy,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [WEIGHT_W-1:0] in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [9:0]                 result
);
   import norm_pkg::*;

   localparam int CNT_W = $clog2(N_WEIGHTS + 1);
   localparam int SQR_W = 2 * WEIGHT_W;

   state_t              state_q, state_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]    beatCnt_q, beatCnt_d;
   logic [ROOT_W-1:0]   root_q, root_d;
   logic [ROOT_W-1:0]   result_q, result_d;

   logic signed [SQR_W-1:0] weightSquare;
   logic [ROOT_W-1:0]       rootNext;
   logic                    rootDone;

   // The single multiplier of the block. A square is never negative, so the
   // product can be zero-extended straight into the unsigned accumulator.
   assign weightSquare = in_data * in_data;

   norm_sqrt_iter #(
      .MAX_ROOT (MAX_ROOT)
   ) u_sqrtIter (
      .acc_i      (acc_q),
      .root_i     (root_q),
      .rootNext_o (rootNext),
      .done_o     (rootDone)
   );

   // Next-state and output logic. Handshake readiness is a pure function of
   // the state, so in_ready drops the cycle after the final beat and
   // out_valid is only ever seen in DONE. result_q is loaded on the way into
   // DONE so it stays frozen while DONE waits and after the hand-off.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      beatCnt_d = beatCnt_q;
      root_d    = root_q;
      result_d  = result_q;
      busy      = 1'b1;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               acc_d     = '0;
               beatCnt_d = '0;
               state_d   = ACCUM;
            end
         end

         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               acc_d = acc_q + ACC_W'($unsigned(weightSquare));
               if (beatCnt_q == CNT_W'(N_WEIGHTS - 1)) begin
                  root_d  = '0;
                  state_d = ROOT;
               end else begin
                  beatCnt_d = beatCnt_q + CNT_W'(1);
               end
            end
         end

         ROOT: begin
            if (rootDone) begin
               result_d = root_q;
               state_d  = DONE;
            end else begin
               root_d = rootNext;
            end
         end

         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers. Reset wins over every request and handshake and wipes
   // any partially accumulated operation, including the published result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         beatCnt_q <= '0;
         root_q    <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         beatCnt_q <= beatCnt_d;
         root_q    <= root_d;
         result_q  <= result_d;
      end
   end

   assign result = {1'b0, result_q};

endmodule : norm_seq

// File: tb/tb_norm_seq.sv
// tb_norm_seq
// Self-checking bench for norm_seq: directed weight sets plus random ones,
// checked against a floor-square-root reference computed from the weights.

module tb_norm_seq;

   localparam int NW      = 20;
   localparam int MAXROOT = 42;

   logic              clk;
   logic              rst;
   logic              start;
   logic              busy;
   logic              in_valid;
   logic              in_ready;
   logic signed [9:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [9:0]        result;

   logic signed [9:0] wq [NW];

   int checkCount;
   int passCount;
   int failCount;

   norm_seq dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just after the rising edge; inputs driven
   // here are sampled on the next edge, outputs read here reflect this edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One comparison point.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: integer square root by definition, then saturation.
   function automatic int refRoot();
      longint sum;
      int r;
      sum = 0;
      for (int i = 0; i < NW; i++) sum += longint'(int'(wq[i])) * longint'(int'(wq[i]));
      r = 0;
      while (longint'(r + 1) * longint'(r + 1) <= sum) r++;
      return (r > MAXROOT) ? MAXROOT : r;
   endfunction

   // Runs one complete operation on the weights in wq.
   // gapMode: 0 back-to-back, 1 idle cycle between beats, 2 random idles.
   task automatic applyStimulus(input string name, input int gapMode, input int holdCycles,
                                input bit startAtDone);
      int expRoot;
      int cyc;
      int gaps;
      expRoot = refRoot();
      checkOutput({name, ".idleBusy"}, busy, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput({name, ".accumBusy"}, busy, 1);
      checkOutput({name, ".accumReady"}, in_ready, 1);
      for (int i = 0; i < NW; i++) begin
         gaps = (gapMode == 1) ? ((i > 0) ? 1 : 0) :
                (gapMode == 2) ? int'($urandom_range(0, 2)) : 0;
         in_valid = 1'b0;
         in_data  = 10'sd0;
         repeat (gaps) tick();
         in_valid = 1'b1;
         in_data  = wq[i];
         tick();
      end
      in_valid = 1'b0;
      in_data  = 10'sd0;
      checkOutput({name, ".readyDropped"}, in_ready, 0);
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 200) begin
         tick();
         cyc++;
      end
      checkOutput({name, ".rootCycles"}, cyc, expRoot + 1);
      checkOutput({name, ".result"}, result, expRoot);
      out_ready = 1'b0;
      for (int k = 0; k < holdCycles; k++) begin
         tick();
         checkOutput({name, ".holdValid"}, out_valid, 1);
         checkOutput({name, ".holdResult"}, result, expRoot);
      end
      out_ready = 1'b1;
      start     = startAtDone;
      tick();
      out_ready = 1'b0;
      start     = 1'b0;
      checkOutput({name, ".postValid"}, out_valid, 0);
      checkOutput({name, ".postBusy"}, busy, 0);
      checkOutput({name, ".postResult"}, result, expRoot);
      tick();
      checkOutput({name, ".stillIdle"}, busy, 0);
   endtask

   initial begin
      int pulses;
      checkCount = 0;
      passCount  = 0;
      failCount  = 0;
      rst        = 1'b1;
      start      = 1'b0;
      in_valid   = 1'b0;
      in_data    = 10'sd0;
      out_ready  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      checkOutput("reset.busy", busy, 0);
      checkOutput("reset.inReady", in_ready, 0);
      checkOutput("reset.outValid", out_valid, 0);
      checkOutput("reset.result", result, 0);

      // All zeros: root 0, a single ROOT cycle.
      foreach (wq[i]) wq[i] = 10'sd0;
      applyStimulus("zeros", 0, 0, 1'b0);

      // All +1: sum 20, root 4.
      foreach (wq[i]) wq[i] = 10'sd1;
      applyStimulus("ones", 0, 0, 1'b0);

      // 3, -4, zeros with idle cycles in between: root 5.
      foreach (wq[i]) wq[i] = 10'sd0;
      wq[0] = 10'sd3;
      wq[1] = -10'sd4;
      applyStimulus("gapped", 1, 0, 1'b0);

      // Full-scale negative weights: sum 5242880, saturated at 42.
      foreach (wq[i]) wq[i] = -10'sd512;
      applyStimulus("saturate", 0, 0, 1'b0);

      // Back-pressure on the result and start during the DONE hand-off.
      foreach (wq[i]) wq[i] = 10'sd0;
      wq[0] = 10'sd3;
      wq[1] = -10'sd4;
      applyStimulus("hold", 0, 5, 1'b1);

      // Reset after seven beats: everything discarded, no stray result.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_data  = 10'sd7;
         tick();
      end
      rst = 1'b1;
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      in_data  = 10'sd0;
      checkOutput("midReset.busy", busy, 0);
      checkOutput("midReset.inReady", in_ready, 0);
      checkOutput("midReset.outValid", out_valid, 0);
      checkOutput("midReset.result", result, 0);
      pulses = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (out_valid === 1'b1 || busy === 1'b1) pulses++;
      end
      checkOutput("midReset.quiet", pulses, 0);
      foreach (wq[i]) wq[i] = 10'sd1;
      applyStimulus("afterReset", 0, 0, 1'b0);

      // Random weight sets, random beat gaps and result back-pressure.
      for (int t = 0; t < 6; t++) begin
         foreach (wq[i]) begin
            if (t < 3) wq[i] = 10'($urandom_range(0, 1023));
            else       wq[i] = 10'(int'($urandom_range(0, 12)) - 6);
         end
         applyStimulus("random", 2, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule : tb_norm_seq
